q_update_unit: RTL and testbench
================================

Name: q_update_unit

Overview:
- Computes the Catmull-Rom spline control-point update for one adaptation step: q[span+k] += e_mu * g_k for k = 0..3.
- g = C^T * [u^3, u^2, u, 1] is the basis vector.
- Sits directly upstream of q_weight_controller. It drives that block's span_ind_read/span_ind_write and q_update_packed, and consumes its q_weight_packed_out.
- The controller rewrites its addressed span every cycle, so this block passes the current weights through whenever it is not committing an update.

Parameters:
- WIDTH, 16, signed fixed-point word width.
- FRAC, 12, fractional bits (1.0 = 0x1000).
- Q, 13, number of spline spans; span index valid range is 0..Q.
- Q_ORD, 4, control points per span (fixed at 4 by the cubic basis).
- SW, $clog2(Q+Q_ORD), span index width.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- start, input, 1: request one update; sampled only in IDLE.
- span_ind, input, SW: span for the update.
- u_frac, input, WIDTH: local abscissa u in [0,1), unsigned in FRAC format.
- e_mu, input, WIDTH: signed mu*error.
- q_weight_packed_in, input, Q_ORD*WIDTH: weights q[span..span+3] from the controller; word k is at bits [WIDTH*k +: WIDTH].
- span_ind_read, output, SW: latched span index.
- span_ind_write, output, SW: always equal to span_ind_read.
- q_update_packed, output, Q_ORD*WIDTH: write data to the controller.
- valid, output, 1: one-cycle pulse marking committed update data.
- busy, output, 1: high in all non-IDLE states.
- err, output, 1: one-cycle pulse when start arrives with span_ind > Q.

Behaviour:
- Reset values (reset low, asynchronous):
  - state = IDLE; span register = 0; u, u2, u3, e_mu and all result registers = 0.
  - valid = 0, busy = 0, err = 0.
- FSM states: IDLE -> POW1 -> POW2 -> UPD0 -> UPD1 -> UPD2 -> UPD3 -> DONE -> IDLE.
- IDLE:
  - start with span_ind <= Q: latch span_ind, u_frac and e_mu, then go to POW1.
  - start with span_ind > Q: pulse err in the next cycle and stay in IDLE; span register unchanged.
- POW1: u2 = (u*u) >>> FRAC.
- POW2: u3 = (u2*u) >>> FRAC.
- UPDk:
  - g_k = column k of C dotted with [u3, u2, u, 1].
  - C rows: [-0.5, 1.5, -1.5, 0.5], [1, -2.5, 2, -0.5], [-0.5, 0, 0.5, 0], [0, 1, 0, 0].
  - Implement with shifts and adds only, no multipliers.
  - p_k = (e_mu * g_k) >>> FRAC, using a full-width product and arithmetic-shift truncation.
  - r_k = sat(q_in[k] + p_k), saturating to [0x8000, 0x7FFF].
- DONE:
  - valid = 1.
  - q_update_packed = {r3, r2, r1, r0} (registered).
  - Return to IDLE next cycle.
- Latency: start sampled at edge T; valid is high during the cycle after edge T+7, exactly one cycle.
- Pass-through: q_update_packed = q_weight_packed_in (combinational) in every state except DONE. This keeps the weights unchanged during idle and computation.
- start while busy: ignored, no queueing, no err.
- reset deasserted mid-operation: the in-flight update is discarded, no valid pulse, and pass-through resumes at span 0.
- Intermediate g_k and product widths: at least WIDTH+4 bits for g_k and 2*WIDTH+4 bits for the product. Overflow is handled only at the final saturation.

Decomposition:
- Package spline_pkg holds:
  - the CR basis constants in FRAC format;
  - the FRAC default;
  - the FSM state encoding (localparams);
  - the sat_add function.
- One sub-module, spline_basis_col: combinational; takes u3, u2, u and column index k; returns g_k. It is reusable by the output interpolation stage.

Test Plan:
1. u_frac = 0, e_mu = 0x1000, span 6, q_in = {0x0C00, 0x0800, 0x0400, 0x0000}, start pulse at T -> valid only in the cycle after edge T+7; q_update_packed = {0x0C00, 0x0800, 0x1400, 0x0000}; span_ind_write = 6.
2. u_frac = 0x0800, e_mu = 0x1000, span 0, q_in = {0xF400, 0xF000, 0xEC00, 0xE800} -> g = {-0.0625, 0.5625, 0.5625, -0.0625}; output {0xF300, 0xF900, 0xF500, 0xE700}.
3. u_frac = 0, e_mu = 0x7FFF, q_in word1 = 0x7000 -> word1 saturates to 0x7FFF; other words unchanged.
4. start with span_ind = 14 (Q = 13) -> err pulses one cycle; busy stays 0. A second start during busy -> no effect; exactly one valid pulse.
5. reset driven low during UPD1 -> busy, valid and err go 0 immediately; span_ind_read = 0; after release, output equals q_weight_packed_in with no valid pulse.
6. IDLE with random q_weight_packed_in -> q_update_packed tracks the input combinationally every cycle.

Source files
------------

// File: rtl/spline_pkg.sv
// spline_pkg
//   Shared definitions for the Catmull-Rom spline datapath:
//   - default word/fraction widths
//   - Catmull-Rom basis matrix C in FRAC (Q.12) format
//   - FSM state encoding for q_update_unit
//   - sat_add: add two signed values and clamp the sum to a w-bit signed range
package spline_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 12;

  // Catmull-Rom basis, row-major, Q.12.
  // g = C^T * [u^3, u^2, u, 1]; g_k takes column k of C.
  localparam logic signed [15:0] CR_BASIS [4][4] = '{
    '{-16'sh0800,  16'sh1800, -16'sh1800,  16'sh0800},
    '{ 16'sh1000, -16'sh2800,  16'sh2000, -16'sh0800},
    '{-16'sh0800,  16'sh0000,  16'sh0800,  16'sh0000},
    '{ 16'sh0000,  16'sh1000,  16'sh0000,  16'sh0000}
  };

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_POW1 = 3'd1;
  localparam state_t ST_POW2 = 3'd2;
  localparam state_t ST_UPD0 = 3'd3;
  localparam state_t ST_UPD1 = 3'd4;
  localparam state_t ST_UPD2 = 3'd5;
  localparam state_t ST_UPD3 = 3'd6;
  localparam state_t ST_DONE = 3'd7;

  // Returns a + b clamped to [-(2^(w-1)), 2^(w-1)-1]. The caller truncates
  // the result to w bits.
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi) begin
      return hi;
    end else if (s < lo) begin
      return lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/spline_basis_col.sv
// spline_basis_col
//   Combinational Catmull-Rom basis evaluator. Returns g_k, the dot product
//   of column k of C with [u^3, u^2, u, 1], using only shifts and adds.
//   Ports:
//     u3_i, u2_i, u_i : unsigned powers of u in FRAC format
//     k_i             : column index 0..3
//     g_o             : signed g_k, WIDTH+4 bits, FRAC format
module spline_basis_col
  import spline_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic [WIDTH-1:0]        u3_i,
  input  logic [WIDTH-1:0]        u2_i,
  input  logic [WIDTH-1:0]        u_i,
  input  logic [1:0]              k_i,
  output logic signed [WIDTH+3:0] g_o
);

  localparam int GW = WIDTH + 4;
  // One extra bit: all coefficients are multiples of 0.5, so the column sum
  // is formed at twice its value (integer coefficients) and halved once at
  // the end. This gives a single floor rounding instead of one per term.
  localparam int XW = WIDTH + 5;
  localparam logic signed [XW-1:0] ONE_X2 = XW'(2) <<< FRAC;

  logic signed [XW-1:0] a3;
  logic signed [XW-1:0] a2;
  logic signed [XW-1:0] a1;
  logic signed [XW-1:0] twice_g;

  assign a3 = $signed({{(XW-WIDTH){1'b0}}, u3_i});
  assign a2 = $signed({{(XW-WIDTH){1'b0}}, u2_i});
  assign a1 = $signed({{(XW-WIDTH){1'b0}}, u_i});

  always_comb begin
    twice_g = '0;
    case (k_i)
      2'd0:    twice_g = (a2 <<< 1) - a3 - a1;                         // -u3 + 2u2 - u
      2'd1:    twice_g = (a3 <<< 1) + a3 - (a2 <<< 2) - a2 + ONE_X2;   // 3u3 - 5u2 + 2
      2'd2:    twice_g = (a2 <<< 2) + a1 - (a3 <<< 1) - a3;            // -3u3 + 4u2 + u
      default: twice_g = a3 - a2;                                      // u3 - u2
    endcase
  end

  assign g_o = GW'(twice_g >>> 1);

endmodule

// File: rtl/q_update_unit.sv
// q_update_unit
//   One Catmull-Rom adaptation step: q[span+k] += e_mu * g_k, k = 0..3,
//   with saturation to the signed WIDTH range. Feeds q_weight_controller,
//   which rewrites the addressed span every cycle, so the current weights are
//   passed through unchanged whenever no update is being committed.
//   Ports:
//     clk, reset (async, active-low)
//     start, span_ind, u_frac, e_mu      : update request (sampled in IDLE)
//     q_weight_packed_in                 : current weights q[span..span+3]
//     span_ind_read, span_ind_write      : latched span index
//     q_update_packed                    : write data to the controller
//     valid                              : one-cycle commit pulse
//     busy                               : high while an update is in flight
//     err                                : one-cycle pulse for span_ind > Q
module q_update_unit
  import spline_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int Q     = 13,
  parameter int Q_ORD = 4,
  parameter int SW    = $clog2(Q + Q_ORD)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SW-1:0]          span_ind,
  input  logic [WIDTH-1:0]       u_frac,
  input  logic [WIDTH-1:0]       e_mu,
  input  logic [Q_ORD*WIDTH-1:0] q_weight_packed_in,
  output logic [SW-1:0]          span_ind_read,
  output logic [SW-1:0]          span_ind_write,
  output logic [Q_ORD*WIDTH-1:0] q_update_packed,
  output logic                   valid,
  output logic                   busy,
  output logic                   err
);

  localparam int GW = WIDTH + 4;
  localparam int PW = 2 * WIDTH + 4;
  localparam logic [SW-1:0] SPAN_MAX = SW'(Q);

  state_t           state_q;
  logic [SW-1:0]    span_q;
  logic [WIDTH-1:0] u_q;
  logic [WIDTH-1:0] u2_q;
  logic [WIDTH-1:0] u3_q;
  logic [WIDTH-1:0] e_mu_q;
  logic [WIDTH-1:0] res_q [Q_ORD];
  logic             valid_q;
  logic             err_q;

  logic [1:0]             k_sel;
  logic [WIDTH-1:0]       pow_op;
  logic [2*WIDTH-1:0]     sq_prod;
  logic [WIDTH-1:0]       pow_d;
  logic signed [GW-1:0]   g_k;
  logic signed [PW-1:0]   prod;
  logic [WIDTH-1:0]       q_word;
  logic [WIDTH-1:0]       r_d;
  logic [Q_ORD*WIDTH-1:0] res_packed;

  // Column index follows the UPDk state.
  always_comb begin
    k_sel = 2'd0;
    case (state_q)
      ST_UPD1: k_sel = 2'd1;
      ST_UPD2: k_sel = 2'd2;
      ST_UPD3: k_sel = 2'd3;
      default: k_sel = 2'd0;
    endcase
  end

  // Shared squarer: POW1 forms u*u, POW2 forms u2*u.
  assign pow_op  = (state_q == ST_POW2) ? u2_q : u_q;
  assign sq_prod = {{WIDTH{1'b0}}, pow_op} * {{WIDTH{1'b0}}, u_q};
  assign pow_d   = WIDTH'(sq_prod >> FRAC);

  spline_basis_col #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_basis (
    .u3_i (u3_q),
    .u2_i (u2_q),
    .u_i  (u_q),
    .k_i  (k_sel),
    .g_o  (g_k)
  );

  // Full-width signed product; the only overflow handling is the final clamp.
  assign prod = $signed({{(PW-WIDTH){e_mu_q[WIDTH-1]}}, e_mu_q})
              * $signed({{(PW-GW){g_k[GW-1]}}, g_k});

  assign q_word = q_weight_packed_in[WIDTH*int'(k_sel) +: WIDTH];
  assign r_d    = WIDTH'(sat_add(64'($signed(q_word)), 64'(prod >>> FRAC), WIDTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      span_q  <= '0;
      u_q     <= '0;
      u2_q    <= '0;
      u3_q    <= '0;
      e_mu_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < Q_ORD; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (span_ind > SPAN_MAX) begin
              err_q <= 1'b1;
            end else begin
              span_q  <= span_ind;
              u_q     <= u_frac;
              e_mu_q  <= e_mu;
              state_q <= ST_POW1;
            end
          end
        end
        ST_POW1: begin
          u2_q    <= pow_d;
          state_q <= ST_POW2;
        end
        ST_POW2: begin
          u3_q    <= pow_d;
          state_q <= ST_UPD0;
        end
        ST_UPD0, ST_UPD1, ST_UPD2, ST_UPD3: begin
          res_q[k_sel] <= r_d;
          state_q      <= state_q + 3'd1;
        end
        ST_DONE: begin
          valid_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < Q_ORD; gi++) begin : g_pack
      assign res_packed[WIDTH*gi +: WIDTH] = res_q[gi];
    end
  endgenerate

  // Committed results are presented only alongside the valid pulse; at all
  // other times the controller's own weights flow straight back.
  assign q_update_packed = valid_q ? res_packed : q_weight_packed_in;
  assign span_ind_read   = span_q;
  assign span_ind_write  = span_q;
  assign valid           = valid_q;
  assign err             = err_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_q_update_unit.sv
module tb_q_update_unit;
  import spline_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  span_ind = '0;
  logic [15:0] u_frac = '0;
  logic [15:0] e_mu = '0;
  logic [63:0] q_in = '0;
  logic [4:0]  span_ind_read;
  logic [4:0]  span_ind_write;
  logic [63:0] q_update_packed;
  logic        valid;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [63:0] exp_data;
    logic [4:0]  span;
    int          exp_cyc;
  } sb_t;
  sb_t sb_q[$];

  q_update_unit dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .span_ind           (span_ind),
    .u_frac             (u_frac),
    .e_mu               (e_mu),
    .q_weight_packed_in (q_in),
    .span_ind_read      (span_ind_read),
    .span_ind_write     (span_ind_write),
    .q_update_packed    (q_update_packed),
    .valid              (valid),
    .busy               (busy),
    .err                (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: floating coefficients applied as Q.12 constants, floor shifts.
  function automatic logic [63:0] cr_model(input logic [15:0] u, input logic [15:0] e,
                                           input logic [63:0] qin);
    longint uu, u2, u3, gs, g, pk, s;
    longint pv [4];
    logic [63:0] out;
    logic [15:0] w;
    uu = longint'(u);
    u2 = ((uu * uu) >>> 12) & 64'hFFFF;
    u3 = ((u2 * uu) >>> 12) & 64'hFFFF;
    pv[0] = u3; pv[1] = u2; pv[2] = uu; pv[3] = 4096;
    out = '0;
    for (int k = 0; k < 4; k++) begin
      gs = 0;
      for (int j = 0; j < 4; j++) gs += longint'(CR_BASIS[j][k]) * pv[j];
      g  = gs >>> 12;
      pk = (longint'($signed(e)) * g) >>> 12;
      w  = qin[16*k +: 16];
      s  = longint'($signed(w)) + pk;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      out[16*k +: 16] = 16'(s);
    end
    return out;
  endfunction

  // Scoreboard consumer: every valid pulse must match the oldest request.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", 64'(valid), 64'd0);
      end else begin
        sb_t it;
        it = sb_q.pop_front();
        $display("txn span=%0d data=%h expected=%h cyc=%0d", span_ind_write,
                 q_update_packed, it.exp_data, cyc);
        chk("upd_data", q_update_packed, it.exp_data);
        chk("upd_span", 64'(span_ind_write), 64'(it.span));
        chk("upd_span_rd", 64'(span_ind_read), 64'(it.span));
        chk("latency", 64'(cyc), 64'(it.exp_cyc));
      end
    end
  end

  task automatic do_start(input logic [4:0] sp, input logic [15:0] u, input logic [15:0] e,
                          input logic [63:0] qin, input logic [63:0] exp, input bit push);
    sb_t it;
    @(posedge clk); #1;
    span_ind = sp; u_frac = u; e_mu = e; q_in = qin; start = 1'b1;
    if (push) begin
      it.exp_data = exp; it.span = sp; it.exp_cyc = cyc + 8;
      sb_q.push_back(it);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", 64'(n < 20), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [63:0] qr, ex;
    logic [15:0] ur, er;
    logic [4:0]  sr;

    // Reset state
    q_in = 64'h1111_2222_3333_4444;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_span", 64'(span_ind_read), 64'd0);
    chk("rst_pass", q_update_packed, q_in);
    reset = 1'b1;

    // 1: u = 0 -> only word1 changes
    do_start(5'd6, 16'h0000, 16'h1000, 64'h0C00_0800_0400_0000, 64'h0C00_0800_1400_0000, 1);
    chk("busy_hi", 64'(busy), 64'd1);
    chk("busy_pass", q_update_packed, q_in);
    wait_idle();

    // 2: u = 0.5
    do_start(5'd0, 16'h0800, 16'h1000, 64'hF400_F000_EC00_E800, 64'hF300_F900_F500_E700, 1);
    wait_idle();

    // 3: saturation on word1, span at upper bound Q
    do_start(5'd13, 16'h0000, 16'h7FFF, 64'h0789_0456_7000_0123, 64'h0789_0456_7FFF_0123, 1);
    wait_idle();

    // 4a: out-of-range span -> err pulse only
    do_start(5'd14, 16'h0100, 16'h1000, 64'h0, 64'h0, 0);
    chk("err_pulse", 64'(err), 64'd1);
    chk("err_busy", 64'(busy), 64'd0);
    chk("err_span_keep", 64'(span_ind_read), 64'd13);
    @(posedge clk); #1;
    chk("err_one_cycle", 64'(err), 64'd0);

    // 4b: start while busy is ignored
    qr = {$urandom, $urandom};
    do_start(5'd4, 16'h0A3C, 16'hF123, qr, cr_model(16'h0A3C, 16'hF123, qr), 1);
    start = 1'b1; span_ind = 5'd2; u_frac = 16'h0400;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_start_err", 64'(err), 64'd0);
    chk("busy_start_span", 64'(span_ind_read), 64'd4);
    wait_idle();

    // Random updates against the model
    for (int i = 0; i < 6; i++) begin
      ur = 16'($urandom_range(0, 16'h0FFF));
      er = 16'($urandom);
      qr = {$urandom, $urandom};
      sr = 5'($urandom_range(0, 13));
      ex = cr_model(ur, er, qr);
      do_start(sr, ur, er, qr, ex, 1);
      wait_idle();
    end

    // 5: asynchronous reset during UPD1 discards the update
    do_start(5'd9, 16'h0600, 16'h2000, 64'h0100_0200_0300_0400, 64'h0, 0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_valid", 64'(valid), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_span", 64'(span_ind_read), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("arst_pass", q_update_packed, q_in);
    chk("arst_idle", 64'(busy), 64'd0);

    // 6: pass-through in IDLE
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      q_in = {$urandom, $urandom};
      #1;
      chk("idle_pass", q_update_packed, q_in);
    end

    @(posedge clk); #1;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
